// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the generic pipeline-stage register: default widths,
// control-bundle bit offsets and a helper that packs the control struct.
package pipe_stage_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int CTRL_W_DEFAULT = 9;

    // Control-bundle bit offsets (WB + M controls).
    localparam int CTRL_REGWRITE     = 0;
    localparam int CTRL_MEMTOREG_LSB = 1;
    localparam int CTRL_MEMTOREG_MSB = 2;
    localparam int CTRL_HALT         = 3;
    localparam int CTRL_MEMREAD      = 4;
    localparam int CTRL_MEMWRITE     = 5;
    localparam int CTRL_LONG_LSB     = 6;
    localparam int CTRL_LONG_MSB     = 7;
    localparam int CTRL_MEMSIGN      = 8;

    typedef struct packed {
        logic       memsign;
        logic [1:0] long_op;
        logic       memwrite;
        logic       memread;
        logic       halt;
        logic [1:0] memtoreg;
        logic       regwrite;
    } ctrl_bundle_t;

    // Places each named control field at its documented bit position.
    function automatic logic [CTRL_W_DEFAULT-1:0] ctrl_pack(input ctrl_bundle_t b);
        logic [CTRL_W_DEFAULT-1:0] r;
        r = '0;
        r[CTRL_REGWRITE]                         = b.regwrite;
        r[CTRL_MEMTOREG_MSB:CTRL_MEMTOREG_LSB]   = b.memtoreg;
        r[CTRL_HALT]                             = b.halt;
        r[CTRL_MEMREAD]                          = b.memread;
        r[CTRL_MEMWRITE]                         = b.memwrite;
        r[CTRL_LONG_MSB:CTRL_LONG_LSB]           = b.long_op;
        r[CTRL_MEMSIGN]                          = b.memsign;
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat channel carrying a packed payload and a control bundle.
// master drives the beat, slave drives ready.
interface pipe_stage_reg_if
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_stage_slot.sv
// One storage entry (valid + data + ctrl) updated on the falling clock edge.
// Flush beats load; clear and flush both keep the data and zero the control.
module pipe_stage_slot
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Entry register: flush wins, then load, then clear.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake and flush.
// Main slot M drives the outputs. With PIPE_STAGE_SKID_EN defined a skid slot
// S is added so o_ready is a registered !S.valid; otherwise ready is passed
// through combinationally and the stage holds a single beat.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stage_reg_if.slave   up,
    pipe_stage_reg_if.master  dn,
    input  logic              i_flush,
    output logic [1:0]        o_occupancy
);

    logic              w_m_valid;
    logic [DATA_W-1:0] w_m_data;
    logic [CTRL_W-1:0] w_m_ctrl;
    logic              w_m_load;
    logic              w_m_clear;
    logic [DATA_W-1:0] w_m_src_data;
    logic [CTRL_W-1:0] w_m_src_ctrl;
    logic              w_up_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_xfer  = up.valid && w_up_ready;
    assign w_out_xfer = w_m_valid && dn.ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              w_s_valid;
    logic [DATA_W-1:0] w_s_data;
    logic [CTRL_W-1:0] w_s_ctrl;
    logic              w_s_load;
    logic              w_s_clear;

    // S can only be full when M is full, so !S.valid is a registered ready.
    assign w_up_ready = !w_s_valid;

    // Slot control: refill M from S first to keep FIFO order, else from input.
    always_comb begin
        w_m_load     = 1'b0;
        w_m_clear    = 1'b0;
        w_s_load     = 1'b0;
        w_s_clear    = 1'b0;
        w_m_src_data = up.data;
        w_m_src_ctrl = up.ctrl;
        if (!w_m_valid) begin
            w_m_load = w_in_xfer;
        end else if (w_out_xfer) begin
            if (w_s_valid) begin
                w_m_load     = 1'b1;
                w_m_src_data = w_s_data;
                w_m_src_ctrl = w_s_ctrl;
                w_s_clear    = 1'b1;
            end else if (w_in_xfer) begin
                w_m_load = 1'b1;
            end else begin
                w_m_clear = 1'b1;
            end
        end else if (w_in_xfer) begin
            w_s_load = 1'b1;
        end
    end

    pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot_s (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_flush (i_flush),
        .i_data  (up.data),
        .i_ctrl  (up.ctrl),
        .o_valid (w_s_valid),
        .o_data  (w_s_data),
        .o_ctrl  (w_s_ctrl)
    );

    assign o_occupancy = {1'b0, w_m_valid} + {1'b0, w_s_valid};
`else
    // Single entry: accept whenever M is empty or is leaving this cycle.
    assign w_up_ready = !w_m_valid || dn.ready;

    // Slot control: load on every accepted beat, empty when a beat leaves alone.
    always_comb begin
        w_m_load     = w_in_xfer;
        w_m_clear    = w_out_xfer && !w_in_xfer;
        w_m_src_data = up.data;
        w_m_src_ctrl = up.ctrl;
    end

    assign o_occupancy = {1'b0, w_m_valid};
`endif

    pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot_m (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_flush (i_flush),
        .i_data  (w_m_src_data),
        .i_ctrl  (w_m_src_ctrl),
        .o_valid (w_m_valid),
        .o_data  (w_m_data),
        .o_ctrl  (w_m_ctrl)
    );

    assign up.ready = w_up_ready;
    assign dn.valid = w_m_valid;
    assign dn.data  = w_m_data;
    // Bubbles carry no control, so a squashed slot can never write state.
    assign dn.ctrl  = w_m_ctrl & {CTRL_W{w_m_valid}};

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
    import pipe_stage_pkg::*;

    localparam int DW = 32;
    localparam int CW = 9;

    logic       clk;
    logic       rst_n;
    logic       i_flush;
    logic [1:0] o_occupancy;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .up          (up_if),
        .dn          (dn_if),
        .i_flush     (i_flush),
        .o_occupancy (o_occupancy)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of bounded depth, emptied by flush or reset.
    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;
    beat_t q[$];

    function automatic bit mdl_ready();
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || (dn_if.ready === 1'b1);
`endif
    endfunction

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            bit in_x;
            bit out_x;
            in_x  = (up_if.valid === 1'b1) && mdl_ready();
            out_x = (q.size() > 0) && (dn_if.ready === 1'b1);
            if (i_flush === 1'b1) begin
                q.delete();
            end else begin
                if (out_x) void'(q.pop_front());
                if (in_x) q.push_back('{up_if.data, up_if.ctrl});
            end
        end
    end

    // Compare DUT against model once per cycle, mid-way between falling edges.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("o_valid", dn_if.valid, q.size() > 0);
            chk("o_occupancy", o_occupancy, q.size());
            chk("o_ctrl", dn_if.ctrl, (q.size() > 0) ? q[0].c : '0);
            chk("o_ready", up_if.ready, mdl_ready());
            if (q.size() > 0) chk("o_data", dn_if.data, q[0].d);
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic r, input logic f);
        @(posedge clk);
        up_if.valid = v;
        up_if.data  = d;
        up_if.ctrl  = c;
        dn_if.ready = r;
        i_flush     = f;
        #2;
    endtask

    initial begin
        ctrl_bundle_t cb;
        rst_n       = 1'b0;
        up_if.valid = 1'b0;
        up_if.data  = '0;
        up_if.ctrl  = '0;
        dn_if.ready = 1'b0;
        i_flush     = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", dn_if.valid, 0);
        chk("rst_data", dn_if.data, 0);
        chk("rst_ctrl", dn_if.ctrl, 0);
        chk("rst_occ", o_occupancy, 0);
        @(posedge clk);
        rst_n = 1'b1;
        #2;
        chk("rst_ready", up_if.ready, 1);

        // Streaming: 0x10..0x17, one per cycle, latency one edge.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h10 + i, 9'(i + 1), 1'b1, 1'b0);
            if (i > 0) begin
                chk("stream_data", dn_if.data, 32'h10 + i - 1);
                chk("stream_valid", dn_if.valid, 1);
            end
        end
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
        chk("stream_last", dn_if.data, 32'h17);
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
        chk("stream_empty", dn_if.valid, 0);

        // Stall with 0xA0, 0xA1 arriving.
        drive(1'b1, 32'hA0, 9'h011, 1'b0, 1'b0);
        drive(1'b1, 32'hA1, 9'h012, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 9'h0, 1'b0, 1'b0);
        chk("stall_data", dn_if.data, 32'hA0);
        chk("stall_ready", up_if.ready, 0);
`ifdef PIPE_STAGE_SKID_EN
        chk("stall_occ", o_occupancy, 2);
`else
        chk("stall_occ", o_occupancy, 1);
`endif
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
`ifndef PIPE_STAGE_SKID_EN
        chk("comb_ready", up_if.ready, 1);
`endif
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        chk("release_a1", dn_if.data, 32'hA1);
        chk("release_a1_v", dn_if.valid, 1);
`else
        chk("release_empty", dn_if.valid, 0);
`endif
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
        chk("drain_empty", dn_if.valid, 0);

        // Flush with beats held and 0xBB offered at the same time.
        drive(1'b1, 32'hB0, 9'h1F0, 1'b0, 1'b0);
        drive(1'b1, 32'hB1, 9'h1F1, 1'b0, 1'b0);
        drive(1'b1, 32'hBB, 9'h1BB, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
        chk("flush_valid", dn_if.valid, 0);
        chk("flush_ctrl", dn_if.ctrl, 0);
        chk("flush_occ", o_occupancy, 0);
        // Flush on an empty stage while a beat is accepted: beat dropped.
        drive(1'b1, 32'hCC, 9'h0CC, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
        chk("flush_drop", dn_if.valid, 0);

        // Bubble masking.
        drive(1'b0, 32'h0, 9'h1FF, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 9'h1FF, 1'b1, 1'b0);
        chk("bubble_ctrl", dn_if.ctrl, 0);
        drive(1'b1, 32'h55, 9'h1FF, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 9'h0, 1'b0, 1'b0);
        chk("full_ctrl", dn_if.ctrl, 9'h1FF);
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);

        // Control offsets: memwrite alone lands on bit 5.
        cb = '0;
        cb.memwrite = 1'b1;
        drive(1'b1, 32'h66, ctrl_pack(cb), 1'b1, 1'b0);
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
        chk("memwrite_bit", dn_if.ctrl, 9'h020);
        chk("memwrite_data", dn_if.data, 32'h66);
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream with beats held.
        drive(1'b1, 32'hC0, 9'h0C0, 1'b0, 1'b0);
        drive(1'b1, 32'hC1, 9'h0C1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 9'h0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", dn_if.valid, 0);
        chk("arst_ctrl", dn_if.ctrl, 0);
        chk("arst_data", dn_if.data, 0);
        chk("arst_occ", o_occupancy, 0);
        @(posedge clk);
        rst_n = 1'b1;
        #2;
        chk("arst_ready", up_if.ready, 1);
        drive(1'b1, 32'hD0, 9'h0D0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
        chk("post_rst_data", dn_if.data, 32'hD0);
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register with valid/ready handshake, flush and an optional two-entry skid buffer. It replaces the fixed per-stage latches (ID/EX, EX/MEM, MEM/WB) of the MIPS core with one generic block. Each instance carries a packed datapath payload and a packed control bundle, and zeroes control on bubbles so a stalled or flushed slot can never write registers or memory.

## Interface
- DATA_W, 32: payload width in bits (e.g. PC, ALU result, read data 2, destination register, packed).
- CTRL_W, 9: control-bundle width in bits (WB + M controls, packed per pipe_stage_pkg).
- clk  in  1  stage clock; all state updates on the falling edge, as in the rest of the core.
- rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  stage can accept a beat.
- i_data  in  DATA_W  upstream payload.
- i_ctrl  in  CTRL_W  upstream control bundle.
- i_flush  in  1  discard all held beats (branch/jump/exception squash).
- o_valid  out  1  downstream beat valid.
- i_ready  in  1  downstream accepts.
- o_data  out  DATA_W  held payload.
- o_ctrl  out  CTRL_W  held control; all zeros whenever o_valid=0.
- o_occupancy  out  2  number of held beats (0..2).

## Operation
- Transfer in: i_valid && o_ready at a falling edge. Transfer out: o_valid && i_ready at a falling edge.
- Storage: main slot M (drives outputs) and skid slot S. o_ready = !S.valid, a registered signal with no combinational path from i_ready.
- The next state at each edge, in priority order:
  - i_flush: M.valid and S.valid cleared; any beat offered in the same cycle is dropped; M/S data retained, ctrl cleared.
  - M empty: an incoming beat loads M.
  - M full, out-transfer: M is loaded from S if S.valid (S is cleared); otherwise M takes the incoming beat if one is present; otherwise M is cleared.
  - M full, no out-transfer, in-transfer: the incoming beat loads S.
  - Otherwise: hold.
- Ordering is strictly FIFO; no beat is duplicated or lost except by flush.
- Bubble rule: o_ctrl = 0 when o_valid = 0. o_data keeps its last value (don't-care downstream).
- o_occupancy = M.valid + S.valid.
- Reset (any time, mid-transfer included): M and S cleared, o_valid=0, o_data=0, o_ctrl=0, o_occupancy=0, o_ready=1 once reset deasserts.

## Timing
- Latency: a beat accepted at edge n appears on o_valid/o_data/o_ctrl after edge n and is stable until it transfers out.
- Throughput: one beat per cycle sustained when i_ready=1.
- One stall cycle with continuous input fills S. o_ready drops after that edge, so upstream sees back-pressure one cycle late and no beat is lost.
- i_flush takes effect at the next edge. Outputs show the empty state after that edge.
- All outputs are registered except o_ctrl, whose masking by M.valid is an AND with no other logic.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry behaviour as above; o_ready is registered; o_occupancy ranges 0..2.
- Undefined: S is removed. o_ready = !M.valid || i_ready (combinational pass-through). M loads on in-transfer and clears on an out-transfer with no in-transfer. o_occupancy ranges 0..1. Flush and reset rules are unchanged.

## Structure
- pipe_stage_pkg holds:
  - control-bundle bit offsets: REGWRITE=0, MEMTOREG=2:1, HALT=3, MEMREAD=4, MEMWRITE=5, LONG=7:6, MEMSIGN=8;
  - default CTRL_W=9.
- Sub-module pipe_stage_slot holds one valid+data+ctrl entry, with load, clear and flush inputs. It is instantiated once for M, and once for S under PIPE_STAGE_SKID_EN.

## Test plan
- Reset: assert rst low mid-stream with 2 beats held -> o_valid=0, o_ctrl=0, o_data=0, o_occupancy=0 immediately; o_ready=1 after release.
- Streaming: 8 beats with data 0x10..0x17, i_ready=1 -> the same order on o_data, one per cycle, latency 1 edge.
- Stall: i_ready=0 for 3 cycles while beats 0xA0, 0xA1 arrive -> o_occupancy=2, o_ready=0, o_data=0xA0. On release, 0xA0 then 0xA1 with no loss or duplication (SKID_EN).
- Flush: flush with 2 beats held and 0xBB offered simultaneously -> next edge o_valid=0, o_ctrl=0x000; 0xBB is never output.
- Bubble masking: i_ctrl=0x1FF with i_valid=0 -> o_ctrl stays 0; with i_valid=1 -> o_ctrl=0x1FF after the edge.
- Macro off: i_ready=0 with M full -> o_ready=0 in the same cycle; i_ready=1 -> o_ready=1 combinationally and throughput is 1 beat/cycle.
